axis_skid_pipeline: RTL
=======================

# axis_skid_pipeline

Parametrised AXI-Stream pipeline of STAGES cascaded skid-buffer stages. It carries full throughput of one beat per cycle and fully registers both the forward path and the backward tready path. It is placed between AXIS blocks on long or congested routes where a combinational tready path would limit timing. It is the successor to the single-stage AXIS register.

## Interface
Parameters:
- AXIS_BYTES, 1: tdata width in bytes; tkeep width.
- AXIS_USER_BITS, 1: tuser width.
- STAGES, 1: number of skid stages, ≥1. Values <1 are an elaboration error.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- sresetn  in  1  synchronous, active-low reset.
- axis_i_tvalid  in  1  slave valid.
- axis_i_tready  out  1  slave ready, driven directly from a flop.
- axis_i_tdata  in  8*AXIS_BYTES  slave data.
- axis_i_tkeep  in  AXIS_BYTES  slave keep.
- axis_i_tlast  in  1  slave last.
- axis_i_tuser  in  AXIS_USER_BITS  slave user.
- axis_o_tvalid  out  1  master valid, driven from a flop.
- axis_o_tready  in  1  master ready.
- axis_o_tdata / _tkeep / _tlast / _tuser  out  widths as slave  master payload, driven from flops.
- occupancy  out  $clog2(2*STAGES+1)  number of beats held. Present only with AXIS_SKID_PIPELINE_OCCUPANCY_EN.

## Operation
- A beat transfers on either side when tvalid && tready in the same cycle.
- Each stage holds a main register, which drives the stage output, and a skid register.
- Stage states:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main valid, skid valid.
- Transitions ("in" = beat accepted into the stage, "out" = beat taken from the stage):
  - EMPTY + in → ONE; main <= input.
  - ONE + in + out → ONE; main <= input.
  - ONE + in, no out → TWO; skid <= input.
  - ONE + out, no in → EMPTY.
  - TWO + out → ONE; main <= skid.
  - TWO never accepts input.
- Stage ready is a register: next value = !(next skid valid). No combinational path exists from the downstream tready to the upstream tready.
- Stage k's output feeds stage k+1's input. Stage 0 is fed by axis_i_*. The last stage drives axis_o_*.
- All payload fields (tdata, tkeep, tlast, tuser) move as one unit. Beat order is preserved. No beat is dropped or duplicated.
- While axis_o_tvalid=1 and axis_o_tready=0, axis_o_* payload stays stable.
- Reset values:
  - All valid flops = 0, so axis_o_tvalid = 0.
  - All ready flops = 0, so axis_i_tready = 0 while sresetn = 0. It rises to 1 on the first cycle after release.
  - occupancy = 0.
  - Payload registers are not reset.
- Reset mid-stream discards every held beat in the cycle sresetn is sampled low.

## Timing
- Forward latency: a beat accepted in cycle N appears on axis_o_tvalid in cycle N+STAGES, if not stalled.
- Throughput: 1 beat/cycle sustained with axis_o_tready held at 1.
- Back-pressure: with axis_o_tready=0 and continuous input, axis_i_tready falls once 2*STAGES beats are held. Each stage's ready drops one cycle after its skid fills.
- Release: after axis_o_tready returns to 1, axis_i_tready rises within STAGES cycles.
- Simultaneous in/out on a stage in ONE keeps it in ONE with no bubble.

## Configuration
- AXIS_SKID_PIPELINE_OCCUPANCY_EN defined:
  - Adds the occupancy output.
  - occupancy is a registered count of valid main+skid entries across all stages, range 0..2*STAGES.
  - It updates in the cycle after the transfers that change it, +1 per input beat and -1 per output beat, both in the same cycle giving net 0.
- Macro undefined: the occupancy port and its counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset: hold sresetn=0 for 4 cycles with axis_i_tvalid=1 → axis_o_tvalid=0 and axis_i_tready=0 throughout. axis_i_tready=1 on the first cycle after release.
- Streaming: STAGES=3, send 100 beats with tdata 0..99 and tlast on beat 99, axis_o_tready=1 → first output 3 cycles after first accept, 1 beat/cycle, data in order, tlast only on 99.
- Stall fill: STAGES=2, axis_o_tready=0, continuous input → exactly 4 beats accepted, then axis_i_tready=0. Output payload stable. occupancy=4 (macro defined).
- Random back-pressure: random tvalid/tready at 50% for 10,000 beats, AXIS_BYTES=4, AXIS_USER_BITS=3 → scoreboard matches all fields, no loss or duplication, no tvalid drop without a transfer.
- Mid-stream reset: 5 beats held, then sresetn=0 for 1 cycle → axis_o_tvalid=0 and occupancy=0 next cycle. Next input beat is the first output beat.
- Ready path: force axis_o_tready to toggle every cycle → axis_i_tready changes only on clock edges, checked by assertion against the registered value.

Source files
------------

// File: rtl/axis_skid_pipeline.sv
// axis_skid_pipeline: STAGES cascaded AXI-Stream skid-buffer stages.
// Forward payload/valid and backward tready are both registered in every
// stage, so there is no combinational path from axis_o_tready to
// axis_i_tready.
// Optional feature: define AXIS_SKID_PIPELINE_OCCUPANCY_EN to add the
// registered 'occupancy' output (beats held across all stages).

// One skid stage: a main register driving the output and a skid register
// that catches the beat arriving in the cycle the downstream stalls.
module axis_skid_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         sresetn,
  input  logic         i_up_valid,
  output logic         o_up_ready,
  input  logic [W-1:0] i_up_data,
  output logic         o_dn_valid,
  input  logic         i_dn_ready,
  output logic [W-1:0] o_dn_data
);

  // Encoding chosen so bit 0 is "main valid" and bit 1 is "skid valid";
  // the output valid is then a flop bit with no decode.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_ready;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_in;
  logic         w_out;
  logic         w_load_main;
  logic         w_load_skid;
  logic         w_main_from_skid;

  // r_ready is 0 in TWO, so a full stage never accepts.
  assign w_in  = i_up_valid && r_ready;
  assign w_out = r_state[0] && i_dn_ready;

  assign o_up_ready = r_ready;
  assign o_dn_valid = r_state[0];
  assign o_dn_data  = r_main;

  // State and ready registers; ready tracks "skid will be empty next cycle".
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_state <= S_EMPTY;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != S_TWO);
    end
  end

  // Next state and payload load strobes.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in && w_out) begin
          w_load_main = 1'b1;
        end else if (w_in) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_out) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_out) begin
          w_state_nxt      = S_ONE;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Payload registers are deliberately not reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_load_main) r_main <= w_main_from_skid ? r_skid : i_up_data;
    if (w_load_skid) r_skid <= i_up_data;
  end

endmodule

module axis_skid_pipeline #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int STAGES         = 1
) (
  input  logic                      clk,
  input  logic                      sresetn,
  input  logic                      axis_i_tvalid,
  output logic                      axis_i_tready,
  input  logic [8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic [AXIS_BYTES-1:0]     axis_i_tkeep,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  output logic                      axis_o_tvalid,
  input  logic                      axis_o_tready,
  output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic [AXIS_BYTES-1:0]     axis_o_tkeep,
  output logic                      axis_o_tlast,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser
`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
  ,
  output logic [$clog2(2*STAGES+1)-1:0] occupancy
`endif
);

  // Whole beat travels as one vector so fields can never skew.
  localparam int PW = 8*AXIS_BYTES + AXIS_BYTES + 1 + AXIS_USER_BITS;

  if (STAGES < 1) begin : g_bad_stages
    $error("axis_skid_pipeline: STAGES must be >= 1");
  end

  // Index k is the link feeding stage k; index STAGES is the output link.
  logic [STAGES:0]         w_vld;
  logic [STAGES:0]         w_rdy;
  logic [STAGES:0][PW-1:0] w_pl;

  assign w_vld[0]      = axis_i_tvalid;
  assign w_pl[0]       = {axis_i_tdata, axis_i_tkeep, axis_i_tlast, axis_i_tuser};
  assign axis_i_tready = w_rdy[0];

  assign w_rdy[STAGES] = axis_o_tready;
  assign axis_o_tvalid = w_vld[STAGES];
  assign {axis_o_tdata, axis_o_tkeep, axis_o_tlast, axis_o_tuser} = w_pl[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    axis_skid_stage #(.W(PW)) u_stage (
      .clk        (clk),
      .sresetn    (sresetn),
      .i_up_valid (w_vld[k]),
      .o_up_ready (w_rdy[k]),
      .i_up_data  (w_pl[k]),
      .o_dn_valid (w_vld[k+1]),
      .i_dn_ready (w_rdy[k+1]),
      .o_dn_data  (w_pl[k+1])
    );
  end

`ifdef AXIS_SKID_PIPELINE_OCCUPANCY_EN
  localparam int OW = $clog2(2*STAGES+1);

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [OW-1:0] r_occ;

  assign w_in_xfer  = axis_i_tvalid && axis_i_tready;
  assign w_out_xfer = axis_o_tvalid && axis_o_tready;
  assign occupancy  = r_occ;

  // Beat count: +1 per accepted input, -1 per delivered output.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_occ <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end
`endif

endmodule
